// File: rtl/layer_result_collector.sv
// layer_result_collector
//   Captures finished neuron values from the MAC core into a first-word-fall-through
//   FIFO, tags each one with its neuron index, and drains them to the host over a
//   valid/ready stream. Tracks progress against the layer length and pulses
//   layer_done when the layer has fully drained.
// Ports
//   clk, reset       clock; asynchronous active-low reset
//   layer_start      begin a layer (pulse), latches layer_len
//   layer_len        neurons in the layer
//   cap_valid/data   capture strobe and MAC output value
//   m_valid/ready    host stream handshake
//   m_data/index     head value and its neuron index
//   m_last           head is the final neuron of the layer
//   level            FIFO occupancy 0..DEPTH
//   busy             collector is not idle
//   layer_done       pulse: layer fully drained
//   overflow         sticky: a capture was dropped
module layer_result_collector #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned IDX_W  = 8,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     layer_start,
   input  logic [IDX_W-1:0]         layer_len,
   input  logic                     cap_valid,
   input  logic [DATA_W-1:0]        cap_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [DATA_W-1:0]        m_data,
   output logic [IDX_W-1:0]         m_index,
   output logic                     m_last,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     busy,
   output logic                     layer_done,
   output logic                     overflow
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [IDX_W-1:0]  idx;
      logic              last;
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DRAIN   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   len_q, len_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [LVL_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_d;
   logic               overflow_d;
   logic               done_d;
   logic               push;
   logic               pop;
   logic               full;
   logic               cap_collect;
   logic               is_last;
   entry_t             mem_q [DEPTH];
   entry_t             head;
   entry_t             wr_entry;

   // FIFO head is presented straight from storage (fall-through)
   assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];
   assign m_data  = head.data;
   assign m_index = head.idx;
   assign m_last  = head.last;

   assign pop         = m_valid && m_ready;
   assign full        = (level == LVL_W'(DEPTH));
   assign cap_collect = (state_q == S_COLLECT) && cap_valid;
   // A full FIFO still takes a push when the head leaves in the same cycle
   assign push        = cap_collect && (!full || pop);
   assign is_last     = (idx_q == IDX_W'(len_q - IDX_W'(1)));
   assign wr_entry    = '{data: cap_data, idx: idx_q, last: is_last};

   // Next-state, counters and flags
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      idx_d      = idx_q;
      overflow_d = overflow;
      done_d     = 1'b0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;

      case (state_q)
         S_IDLE: begin
            if (layer_start && (layer_len != '0)) begin
               len_d      = layer_len;
               idx_d      = '0;
               overflow_d = 1'b0;
               state_d    = S_COLLECT;
            end
         end
         S_COLLECT: begin
            // Index advances even on a dropped capture to keep slots aligned
            if (cap_valid) begin
               idx_d = idx_q + IDX_W'(1);
               if (is_last) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if ((level == '0) || (pop && (level == LVL_W'(1)))) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (cap_valid && (state_q != S_COLLECT)) begin
         overflow_d = 1'b1;
      end
      if (cap_collect && !push) begin
         overflow_d = 1'b1;
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + LVL_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + LVL_W'(1);
      end
      level_d = LVL_W'(wr_ptr_d - rd_ptr_d);
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         idx_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level      <= '0;
         m_valid    <= 1'b0;
         busy       <= 1'b0;
         layer_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level      <= level_d;
         m_valid    <= (level_d != '0);
         busy       <= (state_d != S_IDLE);
         layer_done <= done_d;
         overflow   <= overflow_d;
      end
   end

   // FIFO storage, cleared on reset so the idle head reads as zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_entry;
      end
   end

endmodule
